// File: rtl/mem_port_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_pkg: shared widths and constants for the RAM arbiter      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_W_DEF     = 10;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_EXT  = 2'd2
  } ram_src_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_starve_cnt.sv
// +----------------------------------------------------------------------------+
// | mem_arb_starve_cnt: saturating count of cycles the external port waited    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arb_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             at_max_o
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == C_MAX);
  assign cnt_o    = cnt_q;

  // Clear dominates; increment stops once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: shares the data RAM between the MEM stage and an external|
// | req/gnt port, forcing a one-cycle pipeline stall after a bounded wait.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pipe_req_i,
  input  logic              pipe_write_i,
  input  logic [ADDR_W-1:0] pipe_addr_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  output logic [DATA_W-1:0] pipe_rdata_o,
  output logic              pipe_stall_o,
  input  logic              ext_req_i,
  input  logic              ext_write_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              ext_gnt_o,
  output logic              ext_rvalid_o,
  output logic [DATA_W-1:0] ext_rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  logic             ext_sel, pipe_sel, at_max;
  logic [CNT_W-1:0] starve_cnt;
  ram_src_e         src;

  logic              ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  // Gating with rst_ni keeps the RAM quiet the moment reset drops.
  assign ext_sel  = rst_ni & ext_req_i & (~pipe_req_i | at_max);
  assign pipe_sel = rst_ni & pipe_req_i & ~ext_sel;

  assign ext_gnt_o    = ext_sel;
  assign pipe_stall_o = pipe_req_i & ext_sel;
  assign pipe_rdata_o = ram_rdata_i;

  mem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (ext_sel | ~ext_req_i),
    .inc_i    (ext_req_i & ~ext_sel),
    .cnt_o    (starve_cnt),
    .at_max_o (at_max)
  );

  always_comb begin
    src = SRC_IDLE;
    if (ext_sel) begin
      src = SRC_EXT;
    end else if (pipe_sel) begin
      src = SRC_PIPE;
    end
  end

  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = pipe_addr_i;
    ram_wdata_o = pipe_wdata_i;
    case (src)
      SRC_EXT: begin
        ram_we_o    = ext_write_i;
        ram_addr_o  = ext_addr_i;
        ram_wdata_o = ext_wdata_i;
      end
      SRC_PIPE: ram_we_o = pipe_write_i;
      default:  ram_we_o = 1'b0;
    endcase
  end

  always_comb begin
    ext_rvalid_d = ext_sel & ~ext_write_i;
    ext_rdata_d  = ext_rvalid_d ? ram_rdata_i : ext_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign ext_rvalid_o = ext_rvalid_q;
  assign ext_rdata_o  = ext_rdata_q;

  logic unused_cnt;
  assign unused_cnt = ^starve_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter: scoreboard bench with a RAM model and reference model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pipe_req, pipe_write, ext_req, ext_write;
  logic [9:0] pipe_addr, ext_addr, ram_addr;
  logic [7:0] pipe_wdata, ext_wdata, ram_wdata, ram_rdata, pipe_rdata, ext_rdata;
  logic       pipe_stall, ext_gnt, ext_rvalid, ram_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_W(8), .ADDR_W(10), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pipe_req_i(pipe_req), .pipe_write_i(pipe_write), .pipe_addr_i(pipe_addr),
    .pipe_wdata_i(pipe_wdata), .pipe_rdata_o(pipe_rdata), .pipe_stall_o(pipe_stall),
    .ext_req_i(ext_req), .ext_write_i(ext_write), .ext_addr_i(ext_addr),
    .ext_wdata_i(ext_wdata), .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid),
    .ext_rdata_o(ext_rdata), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Environment RAM: synchronous write, combinational read.
  logic [7:0] ram [1024];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;
  assign ram_rdata = ram[ram_addr];

  typedef struct {
    bit         gnt, stall, we, rvalid, chk_prd;
    logic [9:0] addr;
    logic [7:0] wdata, prd;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] rdq[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model state
  logic [7:0] ref_mem [1024];
  int         waited;
  bit         pending_rd;
  bit         e_req, e_wr;
  logic [9:0] e_addr;
  logic [7:0] e_wd;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("ext_gnt", ext_gnt, mon_e.gnt);
      chk("pipe_stall", pipe_stall, mon_e.stall);
      chk("ram_we", ram_we, mon_e.we);
      chk("ram_addr", ram_addr, mon_e.addr);
      if (mon_e.we) chk("ram_wdata", ram_wdata, mon_e.wdata);
      if (mon_e.chk_prd) chk("pipe_rdata", pipe_rdata, mon_e.prd);
      chk("ext_rvalid", ext_rvalid, mon_e.rvalid);
      if (ext_rvalid) begin
        chk("rdq_nonempty", int'(rdq.size() > 0), 1);
        if (rdq.size() > 0) chk("ext_rdata", ext_rdata, rdq.pop_front());
      end
    end
  end

  task automatic start_ext(input bit w, input logic [9:0] a, input logic [7:0] d);
    e_req = 1'b1; e_wr = w; e_addr = a; e_wd = d;
  endtask

  // One arbitration cycle: drive, predict from the sharing rules, push.
  task automatic cycle(input bit preq, input bit pw, input logic [9:0] pa, input logic [7:0] pwd);
    exp_t e;
    bit   gnt, served_pipe;
    @(posedge clk); #1;
    pipe_req = preq; pipe_write = pw; pipe_addr = pa; pipe_wdata = pwd;
    ext_req = e_req; ext_write = e_wr; ext_addr = e_addr; ext_wdata = e_wd;
    gnt         = e_req && (!preq || waited >= STARVE_MAX);
    served_pipe = preq && !gnt;
    e.gnt     = gnt;
    e.stall   = preq && gnt;
    e.we      = gnt ? e_wr : (served_pipe && pw);
    e.addr    = gnt ? e_addr : pa;
    e.wdata   = gnt ? e_wd : pwd;
    e.chk_prd = served_pipe && !pw;
    e.prd     = ref_mem[pa];
    e.rvalid  = pending_rd;
    if (gnt && !e_wr) rdq.push_back(ref_mem[e_addr]);
    expq.push_back(e);
    if (e.we) ref_mem[e.addr] = e.wdata;
    pending_rd = gnt && !e_wr;
    waited     = (e_req && !gnt) ? waited + 1 : 0;
    if (gnt) e_req = 1'b0;
  endtask

  task automatic drive_all_ones();
    pipe_req = 1; pipe_write = 1; ext_req = 1; ext_write = 1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_gnt"}, ext_gnt, 0);
    chk({tag, "_stall"}, pipe_stall, 0);
    chk({tag, "_rvalid"}, ext_rvalid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    drive_all_ones();
    #1 reset_checks("rst_async");
    repeat (2) @(posedge clk);
    #1 reset_checks("rst_hold");
    chk("rst_rdata", ext_rdata, 0);
    pipe_req = 0; ext_req = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    waited = 0; pending_rd = 0; e_req = 0;
    rdq.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    ram[1023] = 8'h5C; ref_mem[1023] = 8'h5C;
    waited = 0; pending_rd = 0; e_req = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    pipe_addr = 10'h2A; pipe_wdata = 8'h11; ext_addr = 10'h15; ext_wdata = 8'h22;
    rst_n = 1'b0;
    drive_all_ones();
    #3 reset_checks("por");
    repeat (2) @(posedge clk);
    #1 reset_checks("por_hold");
    chk("por_rdata", ext_rdata, 0);
    pipe_req = 0; ext_req = 0;
    @(negedge clk); #1 rst_n = 1'b1;

    // Pipe store then load, no external traffic
    cycle(1, 1, 10'h005, 8'hA3);
    cycle(1, 0, 10'h005, 8'h00);

    // External read with pipeline idle, then return
    start_ext(0, 10'h3FF, 8'h00);
    cycle(0, 0, 10'h001, 8'h00);
    cycle(0, 0, 10'h001, 8'h00);

    // Pipeline busy: forced grant after the wait limit
    start_ext(0, 10'h010, 8'h00);
    repeat (7) cycle(1, 0, 10'($urandom_range(0, 31)), 8'h00);

    // Sustained contention from both sides
    for (int i = 0; i < 20; i++) begin
      if (!e_req) start_ext(1'($urandom), 10'($urandom_range(0, 15)), 8'($urandom));
      cycle(1, 1'($urandom), 10'($urandom_range(0, 15)), 8'($urandom));
    end

    // Reset right after an external read grant
    e_req = 0;
    cycle(0, 0, 10'h000, 8'h00);
    start_ext(0, 10'h3FF, 8'h00);
    cycle(0, 0, 10'h000, 8'h00);
    do_reset();
    start_ext(0, 10'h007, 8'h00);
    repeat (7) cycle(1, 0, 10'h007, 8'h00);

    // Back-to-back external writes then reads, pipeline idle
    for (int i = 0; i < 4; i++) begin
      start_ext(1, 10'(i + 32), 8'(8'hC0 + i));
      cycle(0, 0, 10'h000, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      start_ext(0, 10'(i + 32), 8'h00);
      cycle(0, 0, 10'h000, 8'h00);
    end

    // Randomized traffic over a small address window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      if (!e_req && ($urandom_range(0, 2) == 0))
        start_ext(1'($urandom), 10'($urandom_range(0, 15)), 8'($urandom));
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), 10'($urandom_range(0, 15)), 8'($urandom));
    end

    e_req = 0;
    cycle(0, 0, 10'h000, 8'h00);
    cycle(0, 0, 10'h000, 8'h00);
    @(negedge clk); #1;
    chk("expq_drained", expq.size(), 0);
    chk("rdq_drained", rdq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
